// File: rtl/csa_sub_pkg.sv
// Shared types and constants for the csa8_sub_pipe borrow-select subtractor.
// HALF sets the slice width; keep the top's WIDTH at 2*HALF.
package csa_sub_pkg;
  localparam int WIDTH_DFLT = 8;
  localparam int HALF       = WIDTH_DFLT / 2;

  typedef struct packed {
    logic [HALF-1:0] dl;
    logic            bl;
    logic [HALF-1:0] du0;
    logic            bu0;
    logic [HALF-1:0] du1;
    logic            bu1;
    logic            amsb;
    logic            bmsb;
  } s1_t;
endpackage

// File: rtl/csa8_sub_pipe_if.sv
// Operand/result handshake bundle for csa8_sub_pipe.
// The block attaches through slave; the producer/consumer side uses master.
interface csa8_sub_pipe_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             Ovf;

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, D, Bout, Ovf
  );

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, D, Bout, Ovf
  );
endinterface

// File: rtl/sub4_slice.sv
// Ripple-borrow subtractor slice: d = a - b - bin, bout = borrow out of the MSB.
module sub4_slice #(parameter int W = 4) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);
  logic [W:0] br;

  always_comb begin
    br    = '0;
    d     = '0;
    br[0] = bin;
    for (int i = 0; i < W; i++) begin
      d[i]    = a[i] ^ b[i] ^ br[i];
      br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
    bout = br[W];
  end
endmodule

// File: rtl/csa8_sub_pipe.sv
// Two-stage borrow-select subtractor D = A - B - Bin with valid/ready on both sides.
// Define CSA_SUB_SAT_EN to clamp D to the signed range when Ovf is set.
module csa8_sub_pipe #(
  parameter int WIDTH = csa_sub_pkg::WIDTH_DFLT
) (
  input  logic          clk,
  input  logic          rst_n,
  csa8_sub_pipe_if.slave bus
);
  import csa_sub_pkg::*;

  localparam int MSB = WIDTH - 1;

  s1_t              s1_q;
  s1_t              s1_d;
  logic             s1_valid;
  logic             out_valid_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             ovf_q;

  logic             s2_load;
  logic             in_ready;

  logic [HALF-1:0]  dl, du0, du1;
  logic             bl, bu0, bu1;

  logic [HALF-1:0]  up_sel;
  logic             bout_sel;
  logic             ovf_sel;
  logic [WIDTH-1:0] dwrap;
  logic [WIDTH-1:0] d_sel;

  assign s2_load  = !out_valid_q || bus.out_ready;
  assign in_ready = !s1_valid || s2_load;

  sub4_slice #(.W(HALF)) u_lo (
    .a(bus.A[HALF-1:0]), .b(bus.B[HALF-1:0]), .bin(bus.Bin), .d(dl), .bout(bl)
  );
  // Both upper candidates are computed up front so stage 2 only needs a mux.
  sub4_slice #(.W(HALF)) u_hi0 (
    .a(bus.A[WIDTH-1:HALF]), .b(bus.B[WIDTH-1:HALF]), .bin(1'b0), .d(du0), .bout(bu0)
  );
  sub4_slice #(.W(HALF)) u_hi1 (
    .a(bus.A[WIDTH-1:HALF]), .b(bus.B[WIDTH-1:HALF]), .bin(1'b1), .d(du1), .bout(bu1)
  );

  always_comb begin
    s1_d      = '0;
    s1_d.dl   = dl;
    s1_d.bl   = bl;
    s1_d.du0  = du0;
    s1_d.bu0  = bu0;
    s1_d.du1  = du1;
    s1_d.bu1  = bu1;
    s1_d.amsb = bus.A[MSB];
    s1_d.bmsb = bus.B[MSB];
  end

  always_comb begin
    up_sel   = s1_q.bl ? s1_q.du1 : s1_q.du0;
    bout_sel = s1_q.bl ? s1_q.bu1 : s1_q.bu0;
    dwrap    = {up_sel, s1_q.dl};
    ovf_sel  = (s1_q.amsb != s1_q.bmsb) && (dwrap[MSB] != s1_q.amsb);
    d_sel    = dwrap;
`ifdef CSA_SUB_SAT_EN
    if (ovf_sel) begin
      d_sel = s1_q.amsb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          d_q    <= d_sel;
          bout_q <= bout_sel;
          ovf_q  <= ovf_sel;
        end
      end
      if (in_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_q <= s1_d;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.D         = d_q;
  assign bus.Bout      = bout_q;
  assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_csa8_sub_pipe.sv
// Self-checking bench for csa8_sub_pipe: arithmetic reference model plus scoreboard.
// Honours CSA_SUB_SAT_EN the same way the design does.
module tb_csa8_sub_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   out_cnt = 0;

  typedef struct {
    logic [7:0] d;
    logic       bout;
    logic       ovf;
  } exp_t;

  exp_t q[$];

  csa8_sub_pipe_if #(.WIDTH(8)) bus ();

  csa8_sub_pipe #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction, borrow = negative result.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int         r;
    logic [7:0] dw;
    logic [7:0] dd;
    logic       bo;
    logic       ov;
    r  = int'(a) - int'(b) - int'(bin);
    bo = (r < 0);
    dw = 8'(r & 255);
    ov = (a[7] != b[7]) && (dw[7] != a[7]);
    dd = dw;
`ifdef CSA_SUB_SAT_EN
    if (ov) dd = a[7] ? 8'h80 : 8'h7F;
`endif
    return {ov, bo, dd};
  endfunction

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle.
  initial begin
    exp_t       e;
    logic [9:0] m;
    logic       hold_v;
    logic [9:0] hold_val;
    logic       exp_rdy;
    hold_v   = 1'b0;
    hold_val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        hold_v  = 1'b0;
        acc_cnt = 0;
        out_cnt = 0;
      end else begin
        exp_rdy = !(q.size() == 2 && !bus.out_ready);
        chk("in_ready", 10'(bus.in_ready), 10'(exp_rdy));
        if (hold_v) begin
          chk("stall_valid", 10'(bus.out_valid), 10'd1);
          chk("stall_hold", {bus.Ovf, bus.Bout, bus.D}, hold_val);
        end
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            chk("spurious_out", 10'(bus.out_valid), 10'd0);
          end else if (bus.out_ready) begin
            e = q.pop_front();
            out_cnt++;
            chk("result", {bus.Ovf, bus.Bout, bus.D}, {e.ovf, e.bout, e.d});
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          m = model(bus.A, bus.B, bus.Bin);
          e.d = m[7:0];
          e.bout = m[8];
          e.ovf = m[9];
          q.push_back(e);
          acc_cnt++;
        end
        hold_v   = bus.out_valid && !bus.out_ready;
        hold_val = {bus.Ovf, bus.Bout, bus.D};
      end
    end
  end

  // Hold the given beat on the bus until accepted; leaves in_valid asserted.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic bin);
    bus.A = a;
    bus.B = b;
    bus.Bin = bin;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    errors++;
    $display("FAIL push_timeout actual=stuck required=accept");
  endtask

  task automatic single(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [9:0] exp);
    @(posedge clk);
    #1;
    push(a, b, bin);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1"}, 10'(bus.out_valid), 10'd0);
    @(negedge clk);
    chk({nm, "_lat2"}, 10'(bus.out_valid), 10'd1);
    chk({nm, "_val"}, {bus.Ovf, bus.Bout, bus.D}, exp);
    @(negedge clk);
    chk({nm, "_pulse"}, 10'(bus.out_valid), 10'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Bin = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 10'(bus.out_valid), 10'd0);
    chk("rst_outputs", {bus.Ovf, bus.Bout, bus.D}, 10'h000);
    chk("rst_in_ready", 10'(bus.in_ready), 10'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("model_50_30", model(8'h50, 8'h30, 1'b0), {2'b00, 8'h20});
    chk("model_10_20_1", model(8'h10, 8'h20, 1'b1), {2'b01, 8'hEF});
    chk("model_ff_ff_1", model(8'hFF, 8'hFF, 1'b1), {2'b01, 8'hFF});

    single("d50_30", 8'h50, 8'h30, 1'b0, {2'b00, 8'h20});
    single("d10_20", 8'h10, 8'h20, 1'b1, {2'b01, 8'hEF});
    single("d10_01", 8'h10, 8'h01, 1'b0, {2'b00, 8'h0F});
`ifdef CSA_SUB_SAT_EN
    single("d80_01", 8'h80, 8'h01, 1'b0, {2'b10, 8'h80});
    single("d7f_ff", 8'h7F, 8'hFF, 1'b0, {2'b11, 8'h7F});
`else
    single("d80_01", 8'h80, 8'h01, 1'b0, {2'b10, 8'h7F});
    single("d7f_ff", 8'h7F, 8'hFF, 1'b0, {2'b11, 8'h80});
`endif
    single("dff_ff", 8'hFF, 8'hFF, 1'b1, {2'b01, 8'hFF});

    // Back-to-back beats into a stalled consumer.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    push(8'h33, 8'h11, 1'b0);
    push(8'h05, 8'h09, 1'b1);
    bus.A = 8'hC0;
    bus.B = 8'h41;
    bus.Bin = 1'b0;
    @(negedge clk);
    chk("stall_in_ready", 10'(bus.in_ready), 10'd0);
    chk("stall_in_flight", 10'(q.size()), 10'd2);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    push(8'hC0, 8'h41, 1'b0);
    push(8'h00, 8'h00, 1'b1);
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("stall_drain", 10'(q.size()), 10'd0);
    chk("stall_count", 10'(out_cnt), 10'(acc_cnt));

    // Reset with two beats in flight.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    push(8'hAA, 8'h55, 1'b0);
    push(8'h12, 8'h34, 1'b1);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 10'(bus.out_valid), 10'd0);
    chk("flush_outputs", {bus.Ovf, bus.Bout, bus.D}, 10'h000);
    chk("flush_in_ready", 10'(bus.in_ready), 10'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Random traffic with random back-pressure.
    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(7))
        0: ra = 8'hFF;
        1: rb = 8'hFF;
        2: ra = 8'h80;
        3: rb = 8'h7F;
        default: ;
      endcase
      bus.A = ra;
      bus.B = rb;
      bus.Bin = 1'($urandom);
      bus.in_valid = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(3) != 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rand_drain", 10'(q.size()), 10'd0);
    chk("rand_count", 10'(out_cnt), 10'(acc_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
